// File: rtl/pending_priority_encoder.sv
// Sticky pending-event encoder: latches request pulses, then presents them one
// index at a time through a valid/ready slot, fixed-priority or round-robin.
module pending_priority_encoder #(
  parameter int N  = 8,
  parameter int W  = $clog2(N),
  parameter bit RR = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  output logic [W-1:0] out_idx,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] pending,
  output logic         overflow
);

  logic [W-1:0] ptr;
  logic [W-1:0] ptr_next;
  logic [W-1:0] sel;
  logic         sel_any;
  logic         slot_free;
  logic         load;
  logic [N-1:0] load_mask;

  // Scan starts at ptr in round-robin mode, at 0 otherwise; wrap is at N, not 2^W.
  always_comb begin
    int unsigned base;
    int unsigned j;
    sel     = '0;
    sel_any = 1'b0;
    base    = RR ? int'(ptr) : 0;
    j       = 0;
    for (int unsigned k = 0; k < N; k++) begin
      j = base + k;
      if (j >= N) j = j - N;
      if (!sel_any && pending[j]) begin
        sel     = W'(j);
        sel_any = 1'b1;
      end
    end
  end

  assign slot_free = !out_valid || out_ready;
  assign load      = slot_free && sel_any;
  assign load_mask = load ? (N'(1) << sel) : '0;
  assign ptr_next  = (sel == W'(N - 1)) ? '0 : sel + W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending   <= '0;
      out_idx   <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
      ptr       <= '0;
    end else begin
      // A new event on the line being loaded this edge re-arms it; only merges into
      // a bit that stays pending count as overflow.
      pending  <= (pending & ~load_mask) | req;
      overflow <= |(req & pending & ~load_mask);
      if (load) begin
        out_idx   <= sel;
        out_valid <= 1'b1;
        if (RR) ptr <= ptr_next;
      end else if (slot_free) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pending_priority_encoder.sv
// Bench for pending_priority_encoder: three configurations (N=8 fixed, N=8 RR,
// N=5 RR) checked by scripted scenarios and a transaction-level reference model.
module tb_pending_priority_encoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req_a, req_b;
  logic [4:0] req_c;
  logic       ready_a, ready_b, ready_c;
  logic [2:0] idx_a, idx_b, idx_c;
  logic       valid_a, valid_b, valid_c;
  logic [7:0] pend_a, pend_b;
  logic [4:0] pend_c;
  logic       ovf_a, ovf_b, ovf_c;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state, one entry per DUT
  int         mn[3]  = '{8, 8, 5};
  int         mrr[3] = '{0, 1, 1};
  logic [7:0] m_p[3];
  logic       m_v[3];
  int         m_idx[3];
  int         m_ptr[3];
  logic       m_ovf[3];

  always #5 clk = ~clk;

  pending_priority_encoder #(.N(8), .RR(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n), .req(req_a), .out_idx(idx_a), .out_valid(valid_a),
    .out_ready(ready_a), .pending(pend_a), .overflow(ovf_a));

  pending_priority_encoder #(.N(8), .RR(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .req(req_b), .out_idx(idx_b), .out_valid(valid_b),
    .out_ready(ready_b), .pending(pend_b), .overflow(ovf_b));

  pending_priority_encoder #(.N(5), .RR(1'b1)) dut_c (
    .clk(clk), .rst_n(rst_n), .req(req_c), .out_idx(idx_c), .out_valid(valid_c),
    .out_ready(ready_c), .pending(pend_c), .overflow(ovf_c));

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      m_p[d] = '0; m_v[d] = 1'b0; m_idx[d] = 0; m_ptr[d] = 0; m_ovf[d] = 1'b0;
    end
  endtask

  // Advance one clock edge and apply the spec's transfer rules to the model.
  task automatic tick();
    logic [7:0] r[3];
    logic       rd[3];
    @(posedge clk);
    r[0] = req_a; r[1] = req_b; r[2] = {3'b000, req_c};
    rd[0] = ready_a; rd[1] = ready_b; rd[2] = ready_c;
    for (int d = 0; d < 3; d++) begin
      int n, sel, base;
      logic [7:0] p, mask;
      bit free;
      n = mn[d]; p = m_p[d]; free = !m_v[d] || rd[d];
      base = (mrr[d] != 0) ? m_ptr[d] : 0;
      sel = -1;
      for (int k = 0; k < n; k++)
        if (sel < 0 && p[(base + k) % n]) sel = (base + k) % n;
      mask = (free && sel >= 0) ? (8'd1 << sel) : 8'd0;
      m_ovf[d] = |(r[d] & p & ~mask);
      m_p[d]   = (p & ~mask) | r[d];
      if (mask != 8'd0) begin
        m_idx[d] = sel; m_v[d] = 1'b1;
        if (mrr[d] != 0) m_ptr[d] = (sel + 1) % n;
      end else if (free) begin
        m_v[d] = 1'b0;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_a = '0; req_b = '0; req_c = '0;
    ready_a = 1'b1; ready_b = 1'b1; ready_c = 1'b1;
    model_reset();
    #12;
    n_checks++;
    if ({valid_a, valid_b, valid_c} !== 3'b000) begin
      n_fail++; $display("FAIL reset_valid: got %b expected 000", {valid_a, valid_b, valid_c});
    end
    n_checks++;
    if ({pend_a, pend_b, pend_c} !== 21'd0) begin
      n_fail++; $display("FAIL reset_pending: got %h expected 0", {pend_a, pend_b, pend_c});
    end
    n_checks++;
    if ({idx_a, idx_b, idx_c, ovf_a, ovf_b, ovf_c} !== 12'd0) begin
      n_fail++; $display("FAIL reset_idx_ovf: got %h expected 0", {idx_a, idx_b, idx_c, ovf_a, ovf_b, ovf_c});
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    ready_a = 1'b1;
    for (int i = 0; i < 8; i++) begin
      req_a = 8'd1 << i;
      tick();
      req_a = '0;
      n_checks++;
      if (valid_a !== 1'b0 || pend_a !== (8'd1 << i)) begin
        n_fail++; $display("FAIL single_latch[%0d]: got valid=%b pend=%h expected valid=0 pend=%h", i, valid_a, pend_a, 8'd1 << i);
      end
      tick();
      n_checks++;
      if (valid_a !== 1'b1 || idx_a !== 3'(i) || pend_a !== 8'd0) begin
        n_fail++; $display("FAIL single_idx[%0d]: got valid=%b idx=%0d pend=%h expected valid=1 idx=%0d pend=00", i, valid_a, idx_a, pend_a, i);
      end
      tick();
      n_checks++;
      if (valid_a !== 1'b0) begin
        n_fail++; $display("FAIL single_drain[%0d]: got valid=%b expected 0", i, valid_a);
      end
    end
  endtask

  task automatic test_backpressure();
    int exp_seq[3] = '{2, 4, 7};
    ready_a = 1'b0;
    req_a = 8'b1001_0110;
    tick();
    req_a = '0;
    tick();
    for (int c = 0; c < 5; c++) begin
      n_checks++;
      if (valid_a !== 1'b1 || idx_a !== 3'd1) begin
        n_fail++; $display("FAIL bp_hold[%0d]: got valid=%b idx=%0d expected valid=1 idx=1", c, valid_a, idx_a);
      end
      if (c < 4) tick();
    end
    ready_a = 1'b1;
    for (int s = 0; s < 3; s++) begin
      tick();
      n_checks++;
      if (valid_a !== 1'b1 || idx_a !== 3'(exp_seq[s])) begin
        n_fail++; $display("FAIL bp_seq[%0d]: got valid=%b idx=%0d expected valid=1 idx=%0d", s, valid_a, idx_a, exp_seq[s]);
      end
    end
    tick();
    n_checks++;
    if (valid_a !== 1'b0) begin
      n_fail++; $display("FAIL bp_drain: got valid=%b expected 0", valid_a);
    end
  endtask

  task automatic test_reset_mid();
    ready_a = 1'b0;
    req_a = 8'hA5;
    tick();
    req_a = 8'h00;
    tick();
    req_a = 8'h01;
    tick();
    req_a = 8'h00;
    n_checks++;
    if (pend_a !== 8'hA5 || valid_a !== 1'b1 || ovf_a !== 1'b0) begin
      n_fail++; $display("FAIL mid_setup: got pend=%h valid=%b ovf=%b expected pend=a5 valid=1 ovf=0", pend_a, valid_a, ovf_a);
    end
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if (pend_a !== 8'h00 || valid_a !== 1'b0 || idx_a !== 3'd0 || ovf_a !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset_async: got pend=%h valid=%b idx=%0d ovf=%b expected all 0", pend_a, valid_a, idx_a, ovf_a);
    end
    #2 rst_n = 1'b1;
    ready_a = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_checks++;
      if (valid_a !== 1'b0 || pend_a !== 8'h00) begin
        n_fail++; $display("FAIL mid_after_release[%0d]: got valid=%b pend=%h expected valid=0 pend=00", c, valid_a, pend_a);
      end
    end
  endtask

  task automatic test_round_robin();
    ready_b = 1'b1;
    req_b = 8'hFF;
    tick();
    req_b = '0;
    for (int i = 0; i < 8; i++) begin
      tick();
      n_checks++;
      if (valid_b !== 1'b1 || idx_b !== 3'(i)) begin
        n_fail++; $display("FAIL rr_ff[%0d]: got valid=%b idx=%0d expected valid=1 idx=%0d", i, valid_b, idx_b, i);
      end
    end
    tick();
    for (int rep = 0; rep < 2; rep++) begin
      req_b = 8'b0000_0011;
      tick();
      req_b = '0;
      for (int i = 0; i < 2; i++) begin
        tick();
        n_checks++;
        if (valid_b !== 1'b1 || idx_b !== 3'(i)) begin
          n_fail++; $display("FAIL rr_pair[%0d][%0d]: got valid=%b idx=%0d expected valid=1 idx=%0d", rep, i, valid_b, idx_b, i);
        end
      end
      tick();
    end
    req_b = 8'b0000_0100;
    tick();
    req_b = '0;
    tick();
    tick();
    req_b = 8'b0000_1001;
    tick();
    req_b = '0;
    tick();
    n_checks++;
    if (valid_b !== 1'b1 || idx_b !== 3'd3) begin
      n_fail++; $display("FAIL rr_ptr3_first: got valid=%b idx=%0d expected valid=1 idx=3", valid_b, idx_b);
    end
    tick();
    n_checks++;
    if (valid_b !== 1'b1 || idx_b !== 3'd0) begin
      n_fail++; $display("FAIL rr_ptr3_wrap: got valid=%b idx=%0d expected valid=1 idx=0", valid_b, idx_b);
    end
    tick();
  endtask

  task automatic test_overflow();
    int cnt;
    ready_a = 1'b0;
    req_a = 8'h01;
    tick();
    req_a = 8'h04;
    tick();
    n_checks++;
    if (ovf_a !== 1'b0 || pend_a !== 8'h04) begin
      n_fail++; $display("FAIL ovf_first: got ovf=%b pend=%h expected ovf=0 pend=04", ovf_a, pend_a);
    end
    req_a = 8'h04;
    tick();
    n_checks++;
    if (ovf_a !== 1'b1) begin
      n_fail++; $display("FAIL ovf_pulse: got ovf=%b expected 1", ovf_a);
    end
    req_a = 8'h00;
    tick();
    n_checks++;
    if (ovf_a !== 1'b0) begin
      n_fail++; $display("FAIL ovf_one_cycle: got ovf=%b expected 0", ovf_a);
    end
    ready_a = 1'b1;
    cnt = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (valid_a && idx_a == 3'd2) cnt++;
    end
    n_checks++;
    if (cnt !== 1) begin
      n_fail++; $display("FAIL ovf_merged_once: got %0d deliveries of idx 2 expected 1", cnt);
    end
    req_a = 8'h04;
    tick();
    req_a = 8'h04;
    tick();
    req_a = 8'h00;
    n_checks++;
    if (ovf_a !== 1'b0 || pend_a !== 8'h04) begin
      n_fail++; $display("FAIL rearm_no_ovf: got ovf=%b pend=%h expected ovf=0 pend=04", ovf_a, pend_a);
    end
    cnt = (valid_a && idx_a == 3'd2) ? 1 : 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (valid_a && idx_a == 3'd2) cnt++;
    end
    n_checks++;
    if (cnt !== 2) begin
      n_fail++; $display("FAIL rearm_twice: got %0d deliveries of idx 2 expected 2", cnt);
    end
  endtask

  task automatic test_npot();
    int exp_seq[2] = '{0, 4};
    ready_c = 1'b1;
    for (int rep = 0; rep < 2; rep++) begin
      req_c = 5'b1_0001;
      tick();
      req_c = '0;
      for (int i = 0; i < 2; i++) begin
        tick();
        n_checks++;
        if (valid_c !== 1'b1 || idx_c !== 3'(exp_seq[i])) begin
          n_fail++; $display("FAIL npot_seq[%0d][%0d]: got valid=%b idx=%0d expected valid=1 idx=%0d", rep, i, valid_c, idx_c, exp_seq[i]);
        end
      end
      tick();
      n_checks++;
      if (valid_c !== 1'b0) begin
        n_fail++; $display("FAIL npot_drain[%0d]: got valid=%b expected 0", rep, valid_c);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      req_a = 8'($urandom & $urandom & $urandom);
      req_b = 8'($urandom & $urandom & $urandom);
      req_c = 5'($urandom & $urandom);
      ready_a = ($urandom_range(0, 9) < 7);
      ready_b = ($urandom_range(0, 9) < 5);
      ready_c = ($urandom_range(0, 9) < 8);
      tick();
      n_checks++;
      if (valid_a !== m_v[0] || idx_a !== 3'(m_idx[0]) || pend_a !== m_p[0] || ovf_a !== m_ovf[0]) begin
        n_fail++; $display("FAIL rand_a[%0d]: got v=%b i=%0d p=%h o=%b expected v=%b i=%0d p=%h o=%b", c, valid_a, idx_a, pend_a, ovf_a, m_v[0], m_idx[0], m_p[0], m_ovf[0]);
      end
      n_checks++;
      if (valid_b !== m_v[1] || idx_b !== 3'(m_idx[1]) || pend_b !== m_p[1] || ovf_b !== m_ovf[1]) begin
        n_fail++; $display("FAIL rand_b[%0d]: got v=%b i=%0d p=%h o=%b expected v=%b i=%0d p=%h o=%b", c, valid_b, idx_b, pend_b, ovf_b, m_v[1], m_idx[1], m_p[1], m_ovf[1]);
      end
      n_checks++;
      if (valid_c !== m_v[2] || idx_c !== 3'(m_idx[2]) || pend_c !== m_p[2][4:0] || ovf_c !== m_ovf[2] || idx_c > 3'd4) begin
        n_fail++; $display("FAIL rand_c[%0d]: got v=%b i=%0d p=%h o=%b expected v=%b i=%0d p=%h o=%b", c, valid_c, idx_c, pend_c, ovf_c, m_v[2], m_idx[2], m_p[2][4:0], m_ovf[2]);
      end
    end
    req_a = '0; req_b = '0; req_c = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_reset_mid();
    test_round_robin();
    test_overflow();
    test_npot();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
